// File: rtl/cnt_monitor_pkg.sv
// Shared types and widths for the counter step monitor.
package cnt_monitor_pkg;

  localparam int unsigned ERR_CNT_W = 16;
  localparam int unsigned RUN_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } cnt_mon_state_t;

endpackage

// File: rtl/cnt_monitor_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module cnt_monitor_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cnt_monitor.sv
// Checks that each accepted counter sample is one step from the previous one,
// tracking lock, wrap events and a saturating error tally.
module cnt_monitor
  import cnt_monitor_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned INC_DEC  = 1,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_MAX  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     cnt_in,
  input  logic                 valid_in,
  output logic                 wrap_o,
  output logic                 step_err_o,
  output logic                 locked_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  cnt_mon_state_t       state;
  logic [WIDTH-1:0]     prev;
  logic [RUN_CNT_W-1:0] good_cnt;
  logic [RUN_CNT_W-1:0] bad_cnt;

  logic [WIDTH-1:0]     exp_c;
  logic                 good_c;
  logic                 wrap_pt_c;
  logic                 err_inc_c;
  logic [RUN_CNT_W-1:0] good_nxt_c;
  logic [RUN_CNT_W-1:0] bad_nxt_c;

  // Step expectation; a repeated value never matches exp_c, so it is a mis-step.
  always_comb begin
    exp_c      = (INC_DEC != 0) ? (prev + WIDTH'(1)) : (prev - WIDTH'(1));
    good_c     = (cnt_in == exp_c);
    wrap_pt_c  = (INC_DEC != 0) ? (prev == '1) : (prev == '0);
    err_inc_c  = valid_in && (state != IDLE) && !good_c;
    good_nxt_c = good_cnt + RUN_CNT_W'(1);
    bad_nxt_c  = bad_cnt + RUN_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      wrap_o     <= 1'b0;
      step_err_o <= 1'b0;
      locked_o   <= 1'b0;
    end else begin
      wrap_o     <= 1'b0;
      step_err_o <= 1'b0;
      if (valid_in) begin
        prev <= cnt_in;
        unique case (state)
          IDLE: begin
            state    <= ACQ;
            good_cnt <= '0;
          end
          ACQ: begin
            if (good_c) begin
              wrap_o   <= wrap_pt_c;
              good_cnt <= good_nxt_c;
              if (good_nxt_c == RUN_CNT_W'(LOCK_CNT)) begin
                state    <= LOCKED;
                locked_o <= 1'b1;
                bad_cnt  <= '0;
              end
            end else begin
              good_cnt   <= '0;
              step_err_o <= 1'b1;
            end
          end
          LOCKED: begin
            if (good_c) begin
              wrap_o  <= wrap_pt_c;
              bad_cnt <= '0;
            end else begin
              step_err_o <= 1'b1;
              bad_cnt    <= bad_nxt_c;
              if (bad_nxt_c == RUN_CNT_W'(ERR_MAX)) begin
                state    <= ACQ;
                locked_o <= 1'b0;
                good_cnt <= '0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Lifetime mis-step tally, cleared only by reset.
  cnt_monitor_sat_cnt #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .clr  (rst),
    .inc  (err_inc_c),
    .count(err_cnt_o)
  );

endmodule

// File: tb/tb_cnt_monitor.sv
// Self-checking bench for cnt_monitor: directed vector table, decrement/saturation
// sequences and a randomized stream checked against a behavioural model.
module tb_cnt_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cnt_i, cnt_d;
  logic        valid_i, valid_d;
  logic        wrap_i, err_i, lock_i;
  logic        wrap_d, err_d, lock_d;
  logic [15:0] ec_i, ec_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cnt_monitor #(.WIDTH(8), .INC_DEC(1), .LOCK_CNT(4), .ERR_MAX(3)) dut_inc (
    .clk(clk), .rst(rst), .cnt_in(cnt_i), .valid_in(valid_i),
    .wrap_o(wrap_i), .step_err_o(err_i), .locked_o(lock_i), .err_cnt_o(ec_i)
  );

  cnt_monitor #(.WIDTH(8), .INC_DEC(0), .LOCK_CNT(4), .ERR_MAX(3)) dut_dec (
    .clk(clk), .rst(rst), .cnt_in(cnt_d), .valid_in(valid_d),
    .wrap_o(wrap_d), .step_err_o(err_d), .locked_o(lock_d), .err_cnt_o(ec_d)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [7:0]  cnt;
    logic        wrap;
    logic        err;
    logic        locked;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic r, input logic v, input int c,
                              input logic w, input logic e, input logic l, input int ec);
    vec_t t;
    t.rst = r; t.valid = v; t.cnt = 8'(c);
    t.wrap = w; t.err = e; t.locked = l; t.ec = 16'(ec);
    return t;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic cyc(input logic r, input logic vi, input logic [7:0] ci,
                     input logic vd, input logic [7:0] cd);
    rst = r; valid_i = vi; cnt_i = ci; valid_d = vd; cnt_d = cd;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of the increment monitor (LOCK_CNT=4, ERR_MAX=3).
  bit m_ref, m_locked, m_wrap, m_err;
  int m_prev, m_run, m_bad, m_ec;

  task automatic model_step(input bit r, input bit v, input int c);
    m_wrap = 0; m_err = 0;
    if (r) begin
      m_ref = 0; m_locked = 0; m_prev = 0; m_run = 0; m_bad = 0; m_ec = 0;
    end else if (v) begin
      if (!m_ref) begin
        m_ref = 1; m_run = 0;
      end else if (c == (m_prev + 1) % 256) begin
        m_wrap = (m_prev == 255);
        if (m_locked) m_bad = 0;
        else begin
          m_run++;
          if (m_run == 4) begin m_locked = 1; m_bad = 0; end
        end
      end else begin
        m_err = 1;
        if (m_ec < 65535) m_ec++;
        if (m_locked) begin
          m_bad++;
          if (m_bad == 3) begin m_locked = 0; m_run = 0; end
        end else m_run = 0;
      end
      m_prev = c;
    end
  endtask

  initial begin
    //                 rst   val  cnt  wrap  err  lock ec
    vecs[0]  = mk(1'b1, 1'b0,   0, 1'b0, 1'b0, 1'b0, 0);
    vecs[1]  = mk(1'b0, 1'b1, 250, 1'b0, 1'b0, 1'b0, 0);
    vecs[2]  = mk(1'b0, 1'b1, 251, 1'b0, 1'b0, 1'b0, 0);
    vecs[3]  = mk(1'b0, 1'b1, 252, 1'b0, 1'b0, 1'b0, 0);
    vecs[4]  = mk(1'b0, 1'b1, 253, 1'b0, 1'b0, 1'b0, 0);
    vecs[5]  = mk(1'b0, 1'b1, 254, 1'b0, 1'b0, 1'b1, 0);
    vecs[6]  = mk(1'b0, 1'b1, 255, 1'b0, 1'b0, 1'b1, 0);
    vecs[7]  = mk(1'b0, 1'b1,   0, 1'b1, 1'b0, 1'b1, 0);
    vecs[8]  = mk(1'b0, 1'b1,   1, 1'b0, 1'b0, 1'b1, 0);
    vecs[9]  = mk(1'b0, 1'b0,  77, 1'b0, 1'b0, 1'b1, 0);
    vecs[10] = mk(1'b0, 1'b0,   3, 1'b0, 1'b0, 1'b1, 0);
    vecs[11] = mk(1'b0, 1'b1,   2, 1'b0, 1'b0, 1'b1, 0);
    vecs[12] = mk(1'b0, 1'b1,   4, 1'b0, 1'b1, 1'b1, 1);
    vecs[13] = mk(1'b0, 1'b1,   5, 1'b0, 1'b0, 1'b1, 1);
    vecs[14] = mk(1'b0, 1'b1,   7, 1'b0, 1'b1, 1'b1, 2);
    vecs[15] = mk(1'b0, 1'b1,   7, 1'b0, 1'b1, 1'b1, 3);
    vecs[16] = mk(1'b0, 1'b1,   7, 1'b0, 1'b1, 1'b0, 4);
    vecs[17] = mk(1'b0, 1'b1,   8, 1'b0, 1'b0, 1'b0, 4);
    vecs[18] = mk(1'b1, 1'b1,   9, 1'b0, 1'b0, 1'b0, 0);
    vecs[19] = mk(1'b0, 1'b1, 100, 1'b0, 1'b0, 1'b0, 0);
    vecs[20] = mk(1'b0, 1'b1, 101, 1'b0, 1'b0, 1'b0, 0);
    vecs[21] = mk(1'b0, 1'b1,  50, 1'b0, 1'b1, 1'b0, 1);

    rst = 1'b1; valid_i = 1'b0; valid_d = 1'b0; cnt_i = '0; cnt_d = '0;
    #1;

    for (int i = 0; i < 22; i++) begin
      cyc(vecs[i].rst, vecs[i].valid, vecs[i].cnt, 1'b0, 8'd0);
      check($sformatf("vec%0d.wrap", i), int'(wrap_i), int'(vecs[i].wrap));
      check($sformatf("vec%0d.err", i), int'(err_i), int'(vecs[i].err));
      check($sformatf("vec%0d.locked", i), int'(lock_i), int'(vecs[i].locked));
      check($sformatf("vec%0d.ec", i), int'(ec_i), int'(vecs[i].ec));
    end

    // Decrement direction: 1 -> 0 -> 255 wraps on the last step only.
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
    check("dec_reset.locked", int'(lock_d), 0);
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 8'd1);
    check("dec_ref.err", int'(err_d), 0);
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 8'd0);
    check("dec_1to0.wrap", int'(wrap_d), 0);
    check("dec_1to0.err", int'(err_d), 0);
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 8'd255);
    check("dec_0to255.wrap", int'(wrap_d), 1);
    check("dec_0to255.err", int'(err_d), 0);
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 8'd254);
    check("dec_after_wrap.wrap", int'(wrap_d), 0);
    check("dec_after_wrap.ec", int'(ec_d), 0);

    // Saturation: repeated values are errors; the tally stops at 16'hFFFF.
    for (int n = 1; n <= 65537; n++) begin
      cyc(1'b0, 1'b0, 8'd0, 1'b1, 8'd254);
      if (n == 1 || n == 65534 || n == 65535 || n == 65537) begin
        check($sformatf("sat%0d.ec", n), int'(ec_d), (n < 65535) ? n : 65535);
        check($sformatf("sat%0d.err", n), int'(err_d), 1);
      end
    end

    // Randomized stream against the behavioural model.
    model_step(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
    for (int k = 0; k < 3000; k++) begin
      bit r, v;
      int c;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 99) < 85) ? (m_prev + 1) % 256 : int'($urandom_range(0, 255));
      model_step(r, v, c);
      cyc(r, v, 8'(c), 1'b0, 8'd0);
      check("rnd.wrap", int'(wrap_i), int'(m_wrap));
      check("rnd.err", int'(err_i), int'(m_err));
      check("rnd.locked", int'(lock_i), int'(m_locked));
      check("rnd.ec", int'(ec_i), m_ec);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
